checker_memory_arbiter: RTL

- Shares the single port of the checker memory between two requesters: the Wishbone slave interface (host loading and inspecting memory) and the MPU instruction fetch path.
- Fetches need 48 bits, so each MPU fetch runs as two 32-bit memory reads whose bytes are assembled into one 48-bit word.
- Arbitration is round-robin by default; a build option makes it fixed priority.
- Sits between the Wishbone interconnect and MPU on one side and a checker memory instance with a registered, 1-cycle-latency 32-bit port on the other.

---
 rtl/checker_memory_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/checker_memory_arbiter.sv
// Arbitrates the checker memory port between Wishbone and MPU fetch.
// Define CHECKER_ARB_FIXED_PRIO_EN for fixed MPU priority (default: round-robin).
module checker_memory_arbiter (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        mpu_req,
  input  logic [15:0] mpu_addr,
  output logic        mpu_ack,
  output logic [47:0] mpu_do,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdat,
  input  logic [31:0] mem_rdat
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WB_ISS = 3'd1;
  localparam logic [2:0] S_WB_ACK = 3'd2;
  localparam logic [2:0] S_RD0    = 3'd3;
  localparam logic [2:0] S_RD1    = 3'd4;
  localparam logic [2:0] S_RD2    = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        wb_ack_q, wb_ack_d;
  logic        mpu_ack_q, mpu_ack_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [47:0] mpu_do_q, mpu_do_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic [31:0] mem_wdat_q, mem_wdat_d;

  logic wb_act;
  logic mpu_act;
  logic grant_mpu;
  logic grant_wb;
  logic unused_adr;

  assign unused_adr = ^wb_adr_i[31:16];

  // The ack gating keeps a finished request from being re-granted
  assign wb_act  = wb_cyc_i & wb_stb_i & ~wb_ack_q;
  assign mpu_act = mpu_req & ~mpu_ack_q;

`ifdef CHECKER_ARB_FIXED_PRIO_EN
  assign grant_mpu = mpu_act;
  assign grant_wb  = wb_act & ~mpu_act;
`else
  // last_grant_q: 1 = MPU was granted last, 0 = Wishbone
  logic last_grant_q, last_grant_d;

  assign grant_mpu = mpu_act & (~wb_act | ~last_grant_q);
  assign grant_wb  = wb_act & ~grant_mpu;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == S_IDLE) begin
      if (grant_mpu) begin
        last_grant_d = 1'b1;
      end else if (grant_wb) begin
        last_grant_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    wb_ack_d   = 1'b0;
    mpu_ack_d  = 1'b0;
    wb_dat_d   = wb_dat_q;
    mpu_do_d   = mpu_do_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = mem_we_q;
    mem_sel_d  = mem_sel_q;
    mem_wdat_d = mem_wdat_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_mpu) begin
          state_d    = S_RD0;
          mem_addr_d = mpu_addr;
          mem_we_d   = 1'b0;
        end else if (grant_wb) begin
          state_d    = S_WB_ISS;
          mem_addr_d = wb_adr_i[15:0];
          mem_we_d   = wb_we_i;
          mem_sel_d  = wb_sel_i;
          mem_wdat_d = wb_dat_i;
        end
      end
      S_WB_ISS: begin
        mem_we_d = 1'b0;
        state_d  = S_WB_ACK;
      end
      S_WB_ACK: begin
        wb_dat_d = mem_rdat;
        wb_ack_d = 1'b1;
        state_d  = S_IDLE;
      end
      S_RD0: begin
        mem_addr_d = mpu_addr + 16'd4;
        state_d    = S_RD1;
      end
      S_RD1: begin
        mpu_do_d[31:0] = mem_rdat;
        state_d        = S_RD2;
      end
      S_RD2: begin
        mpu_do_d[47:32] = mem_rdat[15:0];
        mpu_ack_d       = 1'b1;
        state_d         = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      wb_ack_q   <= 1'b0;
      mpu_ack_q  <= 1'b0;
      wb_dat_q   <= 32'h0;
      mpu_do_q   <= 48'h0;
      mem_addr_q <= 16'h0;
      mem_we_q   <= 1'b0;
      mem_sel_q  <= 4'h0;
      mem_wdat_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      wb_ack_q   <= wb_ack_d;
      mpu_ack_q  <= mpu_ack_d;
      wb_dat_q   <= wb_dat_d;
      mpu_do_q   <= mpu_do_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_sel_q  <= mem_sel_d;
      mem_wdat_q <= mem_wdat_d;
    end
  end

  assign wb_ack_o = wb_ack_q;
  assign wb_dat_o = wb_dat_q;
  assign mpu_ack  = mpu_ack_q;
  assign mpu_do   = mpu_do_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign mem_sel  = mem_sel_q;
  assign mem_wdat = mem_wdat_q;

endmodule
